// File: rtl/mdsa_pkg.sv
// Shared types for the MDSA phase sequencer: FSM state encoding, direction modes
// and the per-phase direction vector decode.
// Pure declarations; no timing or flow-control behaviour of its own.
package mdsa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SNAKE = 2'b00;
  localparam logic [1:0] MODE_ASC   = 2'b01;
  localparam logic [1:0] MODE_DESC  = 2'b10;

  localparam int DIR_MAX = 64;

  // Odd phases sort columns (all ascending); even phases alternate 0x55/0xAA by pair index.
  function automatic logic [DIR_MAX-1:0] dir_pattern(input int phase, input logic [1:0] mode,
                                                     input int dir_w);
    logic [DIR_MAX-1:0] mask;
    logic [DIR_MAX-1:0] pat;
    logic [DIR_MAX-1:0] res;
    mask = '0;
    pat  = '0;
    for (int i = 0; i < DIR_MAX; i++) begin
      if (i < dir_w) begin
        mask[i] = 1'b1;
        pat[i]  = ((i % 2) == 0);
      end
    end
    case (mode)
      MODE_ASC:  res = '0;
      MODE_DESC: res = mask;
      default: begin
        if ((phase % 2) == 1)            res = '0;
        else if (((phase / 2) % 2) == 1) res = pat;
        else                             res = ~pat & mask;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdsa_tick_counter.sv
// Phase/drain tick counter with terminal-count flag; wraps to zero at terminal value.
// Latency: tc is combinational from the registered count.
// No backpressure; holds when en is low.
module mdsa_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == term);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/mdsa_phase_sequencer.sv
// MDSA phase sequencer: row/column sort phases, drain, then a one-cycle result pulse.
// Latency: NUM_PHASES*PHASE_CYCLES + DRAIN_CYCLES + 1 enabled cycles from start to output_enable.
// en low freezes everything (strobes stretch); abort returns to IDLE on the next enabled edge.
module mdsa_phase_sequencer
  import mdsa_pkg::*;
#(
  parameter int NUM_PHASES   = 6,
  parameter int PHASE_CYCLES = 10,
  parameter int DRAIN_CYCLES = 10,
  parameter int DIR_W        = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              start,
  input  logic                              abort,
  input  logic [1:0]                        mode,
  output logic [DIR_W-1:0]                  direction,
  output logic                              ready,
  output logic                              trans,
  output logic                              output_enable,
  output logic [$clog2(NUM_PHASES+1)-1:0]   phase_idx
);

  localparam int PW   = $clog2(NUM_PHASES + 1);
  localparam int CMAX = (PHASE_CYCLES > DRAIN_CYCLES) ? PHASE_CYCLES : DRAIN_CYCLES;
  localparam int CW   = $clog2(CMAX);

  localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] PHASE_MAX  = PW'(NUM_PHASES);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

  state_t        state, state_d;
  logic [PW-1:0] phase, phase_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_term;
  logic          cnt_tc;
  logic          cnt_en;
  logic          cnt_clr;

  logic [DIR_MAX-1:0] dir_full;

  // RUN and DRAIN share one counter; only the terminal value changes.
  assign cnt_term = (state == DRAIN) ? DRAIN_LAST : PHASE_LAST;

  mdsa_tick_counter #(.W(CW)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .term  (cnt_term),
    .count (cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      phase  <= '0;
      mode_q <= MODE_SNAKE;
    end else begin
      state  <= state_d;
      phase  <= phase_d;
      mode_q <= mode_d;
    end
  end

  assign dir_full = dir_pattern(int'(phase), mode_q, DIR_W);

  generate
    if (DIR_W < DIR_MAX) begin : g_dir_unused
      logic dir_unused;
      assign dir_unused = ^dir_full[DIR_MAX-1:DIR_W];
    end
  endgenerate

  always_comb begin
    state_d       = state;
    phase_d       = phase;
    mode_d        = mode_q;
    cnt_en        = 1'b0;
    cnt_clr       = 1'b0;
    ready         = 1'b0;
    trans         = 1'b0;
    output_enable = 1'b0;
    direction     = '0;
    phase_idx     = '0;

    if (en) begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state_d = RUN;
            phase_d = PHASE_ONE;
            mode_d  = mode;
          end
        end
        RUN: begin
          if (abort) begin
            state_d = IDLE;
            phase_d = '0;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
              if (phase < PHASE_MAX) begin
                phase_d = phase + PHASE_ONE;
              end else begin
                state_d = DRAIN;
                phase_d = '0;
              end
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (cnt_tc) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Moore decode from registered state only.
    case (state)
      IDLE: ready = 1'b1;
      RUN: begin
        phase_idx = phase;
        direction = dir_full[DIR_W-1:0];
        trans     = ((phase == PHASE_ONE) && (cnt == CNT_ONE)) || (cnt == PHASE_LAST);
      end
      DONE: begin
        trans         = 1'b1;
        output_enable = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mdsa_phase_sequencer.md
Name: mdsa_phase_sequencer

Overview:
- Parametrised phase controller for the multidimensional sort array (MDSA). It generalises the fixed 6-phase, 10-cycle controller.
- Sequences a configurable number of row/column sort phases with configurable per-phase and drain durations.
- Emits per-phase direction vectors in a selectable mode (snake, all-ascending, all-descending), plus transfer strobes, a ready flag and an output-enable pulse.
- Supports clock-enable stall and abort.
- Sits between the host start handshake and the comparator array datapath.

Parameters:
- NUM_PHASES, 6: number of sort phases; legal range ≥1.
- PHASE_CYCLES, 10: cycles per phase; legal range ≥3.
- DRAIN_CYCLES, 10: cycles between the last phase and output enable; legal range ≥1.
- DIR_W, 8: direction vector width, one bit per comparator lane.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable. Low freezes all state, counters and outputs.
- start  in  1  begin a sort. Sampled only when en=1 and in IDLE.
- abort  in  1  cancel the sort in progress. Sampled when en=1.
- mode  in  2  direction mode, latched at start: 00 snake, 01 all ascending, 10 all descending, 11 treated as 00.
- direction  out  DIR_W  comparator direction per lane.
- ready  out  1  high only in IDLE.
- trans  out  1  one-cycle load/transfer strobe.
- output_enable  out  1  one-cycle result-valid pulse.
- phase_idx  out  $clog2(NUM_PHASES+1)  current phase, 1..NUM_PHASES; 0 outside RUN.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, cnt=0, phase=0, mode_q=00. Outputs become ready=1, trans=0, output_enable=0, direction=0, phase_idx=0. rst has priority over en, start and abort.
- Outputs are Moore: decoded only from registered state, cnt, phase and mode_q. There is no combinational path from inputs to outputs.
- States:
  - IDLE: on en & start & !abort → RUN with phase=1, cnt=0, mode_q=mode.
  - RUN: cnt increments every enabled cycle. At cnt==PHASE_CYCLES-1:
    - if phase<NUM_PHASES: phase+1, cnt=0;
    - else → DRAIN, cnt=0.
  - DRAIN: cnt increments. At cnt==DRAIN_CYCLES-1 → DONE.
  - DONE: lasts one cycle, then → IDLE.
- Output decode:
  - ready=1 only in IDLE.
  - output_enable=1 only in DONE.
  - trans=1 in three cases: RUN with phase==1 and cnt==1 (load strobe); RUN with cnt==PHASE_CYCLES-1 (end of phase); and DONE.
- Direction, for phase p in RUN:
  - mode 00: if p is odd (column phase), direction=0. If p is even, let k=p/2. For odd k, direction=PAT, where bit i=1 for even i (0x55 at DIR_W=8). For even k, direction=~PAT (0xAA).
  - mode 01: direction=0 in every phase.
  - mode 10: direction=all ones in every phase.
  - Outside RUN: direction=0.
- Latency at defaults: start sampled at edge 0 → RUN occupies cycles 1–60 → DRAIN 61–70 → DONE 71 → ready=1 at cycle 72.
  - Total from start to output_enable = NUM_PHASES*PHASE_CYCLES + DRAIN_CYCLES + 1 enabled cycles.
  - A run produces NUM_PHASES+2 trans pulses.
- Stall: with en=0, no register changes and outputs hold their values. A trans or output_enable pulse held by a stall therefore stretches; downstream logic qualifies these strobes with en.
- Ignored inputs:
  - start outside IDLE is ignored.
  - start together with abort in IDLE is ignored.
  - abort in IDLE has no effect.
- Abort: with en & abort in RUN, DRAIN or DONE → IDLE next cycle with cnt=0 and phase=0. No output_enable or trans is issued on the abort edge.
- Back-to-back runs: start asserted in the first IDLE cycle after DONE is accepted.
- Widths:
  - cnt is $clog2(max(PHASE_CYCLES,DRAIN_CYCLES)) bits and never wraps; it is cleared explicitly at terminal count.
  - phase never exceeds NUM_PHASES.

Decomposition:
- Package mdsa_pkg holds:
  - the state encoding (IDLE, RUN, DRAIN, DONE);
  - mode constants (MODE_SNAKE, MODE_ASC, MODE_DESC);
  - a function dir_pattern(phase, mode, DIR_W) that returns the direction vector.
- One sub-module, mdsa_tick_counter, is natural. It is parametrised by width and has enable, clear and terminal-value inputs, and outputs count plus a tc flag. RUN and DRAIN share one instance by muxing the terminal value.

Test Plan:
- Defaults, mode 00, start at cycle 0 with en=1 constantly:
  - phase_idx steps 1..6 every 10 cycles;
  - direction is 0x55 in phase 2, 0xAA in phase 4, 0 otherwise;
  - trans at cycles 2, 10, 20, 30, 40, 50, 60 and 71 (8 pulses);
  - output_enable only at cycle 71; ready returns at 72.
- NUM_PHASES=8, mode 00: direction is 0x55 in phases 2 and 6, 0xAA in phases 4 and 8. Mode 10 run: direction=0xFF in all 8 phases. Mode 11 behaves exactly as mode 00.
- en deasserted for 5 cycles in the middle of phase 3: phase_idx, direction and cnt hold; output_enable shifts to cycle 76; the number of trans pulse events is unchanged.
- abort at cycle 35 (phase 4): IDLE with ready=1 at cycle 36; output_enable never asserts; a start at 36 begins a clean run with phase_idx=1.
- rst pulsed at cycle 65 (DRAIN) together with abort and start: all outputs return to reset values next cycle; no output_enable.
- start asserted at cycles 20 and 71 (not in IDLE): ignored. start in the first IDLE cycle after DONE: second run accepted with no gap.
